axi_lite_reg_slave: RTL and testbench

- AXI4-Lite responder: the slave end of the AXI4-Lite interface, terminating the master's five channels.
- Implements a bank of NUM_REGS 32-bit read/write registers.
- Register contents are exported as a flat bus, with per-register write strobes, for use by local logic.
- Holds at most one outstanding write and one outstanding read; write and read paths run independently.

---
 rtl/axi_lite_reg_slave.sv | 218 +++++++++++++++++++++
 tb/tb_axi_lite_reg_slave.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_reg_slave.sv
// rtl/axi_lite_reg_slave.sv - AXI4-Lite slave terminating a bank of 32-bit read/write registers
//
// Purpose: answers AXI4-Lite writes and reads against NUM_REGS registers and
// exports the register contents plus one-cycle write pulses to local logic.
// Optional feature macro: AXIL_REG_SLAVE_WSTRB_EN (defined: wstrb byte-lane
// masking; undefined: every in-range write replaces the whole word).
//
// Ports:
//   aclk, areset                  clock (posedge), asynchronous active-high reset
//   awaddr/awvalid/awready        write address channel
//   wdata/wstrb/wvalid/wready     write data channel
//   bresp/bvalid/bready           write response channel
//   araddr/arvalid/arready        read address channel
//   rdata/rresp/rvalid/rready     read data channel
//   reg_q                         flat register contents, reg i at [32*i+31:32*i]
//   reg_wr                        one-cycle pulse per register written
module axi_lite_reg_slave #(
  parameter int          ADDR_W    = 32,
  parameter int          DATA_W    = 32,
  parameter int          NUM_REGS  = 8,
  parameter logic [31:0] RESET_VAL = 32'h0
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic [ADDR_W-1:0]          awaddr,
  input  logic                       awvalid,
  output logic                       awready,
  input  logic [DATA_W-1:0]          wdata,
  input  logic [DATA_W/8-1:0]        wstrb,
  input  logic                       wvalid,
  output logic                       wready,
  output logic [1:0]                 bresp,
  output logic                       bvalid,
  input  logic                       bready,
  input  logic [ADDR_W-1:0]          araddr,
  input  logic                       arvalid,
  output logic                       arready,
  output logic [DATA_W-1:0]          rdata,
  output logic [1:0]                 rresp,
  output logic                       rvalid,
  input  logic                       rready,
  output logic [NUM_REGS*DATA_W-1:0] reg_q,
  output logic [NUM_REGS-1:0]        reg_wr
);

  localparam int         IDX_W  = ADDR_W - 2;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_VALID} r_state_e;

  w_state_e              w_state_q, w_state_d;
  r_state_e              r_state_q, r_state_d;
  logic [DATA_W-1:0]     regs_q [NUM_REGS];
  logic [DATA_W-1:0]     regs_d [NUM_REGS];
  logic [IDX_W-1:0]      aw_idx_q, aw_idx_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W/8-1:0]   wstrb_q, wstrb_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [NUM_REGS-1:0]   reg_wr_q, reg_wr_d;

  logic                  aw_held, w_held, aw_hs, w_hs, ar_hs, w_commit;
  logic                  w_in_range, r_in_range;
  logic [IDX_W-1:0]      w_idx, r_idx;
  logic [DATA_W-1:0]     w_data_eff;
  logic [DATA_W/8-1:0]   w_strb_eff;

  assign aw_held = (w_state_q == W_HAVE_AW);
  assign w_held  = (w_state_q == W_HAVE_W);

  // Readies depend only on registered state (and reset), never on a valid input.
  assign awready = !areset && !aw_held && !bvalid_q;
  assign wready  = !areset && !w_held && !bvalid_q;
  assign arready = !areset && !rvalid_q;

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;
  assign ar_hs = arvalid && arready;

  // A held beat takes priority over the live bus; the live bus is only used on its handshake.
  assign w_idx      = aw_held ? aw_idx_q : awaddr[ADDR_W-1:2];
  assign w_data_eff = w_held ? wdata_q : wdata;
  assign w_strb_eff = w_held ? wstrb_q : wstrb;
  assign w_commit   = (aw_held || aw_hs) && (w_held || w_hs);
  assign w_in_range = (w_idx < IDX_W'(NUM_REGS));

  assign r_idx      = araddr[ADDR_W-1:2];
  assign r_in_range = (r_idx < IDX_W'(NUM_REGS));

  always_comb begin
    w_state_d = w_state_q;
    aw_idx_d  = aw_idx_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    regs_d    = regs_q;
    reg_wr_d  = '0;

    if (aw_hs) aw_idx_d = awaddr[ADDR_W-1:2];
    if (w_hs) begin
      wdata_d = wdata;
      wstrb_d = wstrb;
    end

    case (w_state_q)
      W_IDLE: begin
        if (w_commit)   w_state_d = W_RESP;
        else if (aw_hs) w_state_d = W_HAVE_AW;
        else if (w_hs)  w_state_d = W_HAVE_W;
      end
      W_HAVE_AW, W_HAVE_W: begin
        if (w_commit) w_state_d = W_RESP;
      end
      W_RESP: begin
        if (bready) begin
          w_state_d = W_IDLE;
          bvalid_d  = 1'b0;
        end
      end
      default: w_state_d = W_IDLE;
    endcase

    if (w_commit) begin
      bvalid_d = 1'b1;
      bresp_d  = w_in_range ? OKAY : SLVERR;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_in_range && (w_idx == IDX_W'(i))) begin
`ifdef AXIL_REG_SLAVE_WSTRB_EN
          for (int b = 0; b < DATA_W/8; b++) begin
            if (w_strb_eff[b]) regs_d[i][8*b +: 8] = w_data_eff[8*b +: 8];
          end
`else
          regs_d[i] = w_data_eff;
`endif
          // Pulses even for an all-zero strobe: the register was addressed.
          reg_wr_d[i] = 1'b1;
        end
      end
    end
  end

  // Reads sample regs_q, so a read committing with a write to the same
  // register at one edge returns the pre-write value.
  always_comb begin
    r_state_d = r_state_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (r_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          r_state_d = R_VALID;
          rvalid_d  = 1'b1;
          rresp_d   = r_in_range ? OKAY : SLVERR;
          rdata_d   = '0;
          for (int i = 0; i < NUM_REGS; i++) begin
            if (r_in_range && (r_idx == IDX_W'(i))) rdata_d = regs_q[i];
          end
        end
      end
      R_VALID: begin
        if (rready) begin
          r_state_d = R_IDLE;
          rvalid_d  = 1'b0;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
      aw_idx_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= 2'b00;
      reg_wr_q  <= '0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      regs_q    <= regs_d;
      aw_idx_q  <= aw_idx_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      reg_wr_q  <= reg_wr_d;
    end
  end

  assign bvalid = bvalid_q;
  assign bresp  = bresp_q;
  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;
  assign rresp  = rresp_q;
  assign reg_wr = reg_wr_q;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign reg_q[DATA_W*g +: DATA_W] = regs_q[g];
  end

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// tb/tb_axi_lite_reg_slave.sv - scoreboard bench for axi_lite_reg_slave
module tb_axi_lite_reg_slave;
  localparam int NR = 8;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic [31:0]   awaddr = '0, wdata = '0, araddr = '0;
  logic [3:0]    wstrb = '0;
  logic          awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic          awready, wready, bvalid, arready, rvalid;
  logic [1:0]    bresp, rresp;
  logic [31:0]   rdata;
  logic [NR*32-1:0] reg_q;
  logic [NR-1:0] reg_wr;

  axi_lite_reg_slave #(.ADDR_W(32), .DATA_W(32), .NUM_REGS(NR), .RESET_VAL(32'h0)) dut (
    .aclk(aclk), .areset(areset),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .reg_q(reg_q), .reg_wr(reg_wr)
  );

  always #5 aclk = ~aclk;

  typedef struct packed { logic [1:0] resp; logic [31:0] data; } rexp_t;

  int            checks = 0;
  int            errors = 0;
  logic [31:0]   model [NR];
  logic [1:0]    exp_b [$];
  rexp_t         exp_r [$];
  logic [NR-1:0] exp_wr [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference write: bytes with a set strobe take the new data, the rest keep the old.
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
`ifdef AXIL_REG_SLAVE_WSTRB_EN
    logic [31:0] mask;
    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (old & ~mask) | (d & mask);
`else
    return d;
`endif
  endfunction

  function automatic rexp_t read_exp(input logic [31:0] addr);
    rexp_t e;
    int idx;
    idx = int'(addr >> 2);
    if (idx < NR) begin e.resp = 2'b00; e.data = model[idx]; end
    else          begin e.resp = 2'b10; e.data = 32'h0; end
    return e;
  endfunction

  // Starts and ends just after a rising edge; the handshake happens at the edge it returns after.
  task automatic wait_hs(input int ch, input string name);
    int n;
    logic hs;
    n = 0;
    hs = 1'b0;
    while (!hs) begin
      @(negedge aclk);
      case (ch)
        0:       hs = awready;
        1:       hs = wready;
        default: hs = arready;
      endcase
      @(posedge aclk); #1;
      n++;
      if (!hs && n > 100) begin
        checks++; errors++;
        $display("FAIL timeout %s", name);
        return;
      end
    end
  endtask

  task automatic wait_valid(input int ch, input string name);
    int n;
    logic v;
    n = 0;
    do begin
      @(negedge aclk);
      v = (ch == 0) ? bvalid : rvalid;
      n++;
    end while (!v && n < 100);
    if (!v) begin
      checks++; errors++;
      $display("FAIL timeout %s", name);
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int daw, input int dw, input int db);
    int idx;
    logic [NR-1:0] m;
    logic [1:0] eb;
    idx = int'(addr >> 2);
    if (idx < NR) begin
      model[idx] = merge(model[idx], data, strb);
      m = '0;
      m[idx] = 1'b1;
      exp_wr.push_back(m);
      eb = 2'b00;
    end else begin
      eb = 2'b10;
    end
    exp_b.push_back(eb);
    fork
      begin
        repeat (daw) begin @(posedge aclk); #1; end
        awaddr = addr; awvalid = 1'b1;
        wait_hs(0, "aw_handshake");
        awvalid = 1'b0;
        @(negedge aclk);
        chk("awready_after_aw", awready, 0);
      end
      begin
        repeat (dw) begin @(posedge aclk); #1; end
        wdata = data; wstrb = strb; wvalid = 1'b1;
        wait_hs(1, "w_handshake");
        wvalid = 1'b0;
        @(negedge aclk);
        chk("wready_after_w", wready, 0);
      end
    join
    wait_valid(0, "bvalid");
    @(posedge aclk); #1;
    repeat (db) begin
      @(negedge aclk);
      chk("bvalid_hold", bvalid, 1);
      chk("bresp_hold", bresp, eb);
      chk("awready_hold", awready, 0);
      chk("wready_hold", wready, 0);
      @(posedge aclk); #1;
    end
    bready = 1'b1;
    @(posedge aclk); #1;
    bready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr, input rexp_t e, input int dar, input int dr);
    exp_r.push_back(e);
    repeat (dar) begin @(posedge aclk); #1; end
    araddr = addr; arvalid = 1'b1;
    wait_hs(2, "ar_handshake");
    arvalid = 1'b0;
    wait_valid(1, "rvalid");
    @(posedge aclk); #1;
    repeat (dr) begin
      @(negedge aclk);
      chk("rvalid_hold", rvalid, 1);
      chk("rdata_hold", rdata, e.data);
      chk("rresp_hold", {30'd0, rresp}, {30'd0, e.resp});
      chk("arready_hold", arready, 0);
      @(posedge aclk); #1;
    end
    rready = 1'b1;
    @(posedge aclk); #1;
    rready = 1'b0;
  endtask

  // Write issued together with a read at the same edge; the read sees the pre-write value.
  task automatic do_both(input logic [31:0] wa, input logic [31:0] wd, input logic [3:0] ws,
                         input logic [31:0] ra, input int db, input int dr);
    rexp_t e;
    e = read_exp(ra);
    fork
      do_write(wa, wd, ws, 0, 0, db);
      do_read(ra, e, 0, dr);
    join
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a completing response.
  always @(negedge aclk) begin
    logic [1:0]    eb;
    rexp_t         er;
    logic [NR-1:0] ew;
    if (!areset) begin
      if (bvalid && bready) begin
        if (exp_b.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_b bresp=%b", bresp);
        end else begin
          eb = exp_b.pop_front();
          chk("bresp", {30'd0, bresp}, {30'd0, eb});
          for (int i = 0; i < NR; i++) chk($sformatf("reg_q[%0d]", i), reg_q[32*i +: 32], model[i]);
        end
      end
      if (rvalid && rready) begin
        if (exp_r.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_r rdata=%h", rdata);
        end else begin
          er = exp_r.pop_front();
          chk("rdata", rdata, er.data);
          chk("rresp", {30'd0, rresp}, {30'd0, er.resp});
        end
      end
      if (reg_wr != '0) begin
        if (exp_wr.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_reg_wr reg_wr=%b", reg_wr);
        end else begin
          ew = exp_wr.pop_front();
          chk("reg_wr", {24'd0, reg_wr}, {24'd0, ew});
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int op;
    logic [31:0] a, d, ra;
    for (int i = 0; i < NR; i++) model[i] = 32'h0;

    #12;
    chk("rst_awready", awready, 0);
    chk("rst_wready", wready, 0);
    chk("rst_arready", arready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_bresp", {30'd0, bresp}, 0);
    chk("rst_reg_wr", {24'd0, reg_wr}, 0);
    for (int i = 0; i < NR; i++) chk("rst_reg_q", reg_q[32*i +: 32], 32'h0);
    @(negedge aclk);
    areset = 1'b0;
    #1;
    chk("rel_awready", awready, 1);
    chk("rel_wready", wready, 1);
    chk("rel_arready", arready, 1);
    @(posedge aclk); #1;

    do_write(32'h04, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    do_read(32'h04, read_exp(32'h04), 0, 0);
    do_write(32'h08, 32'h12345678, 4'hF, 3, 0, 1);
    do_read(32'h08, read_exp(32'h08), 1, 0);
    do_write(32'h0C, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
    do_write(32'h0C, 32'h00000000, 4'b0101, 1, 0, 0);
    do_read(32'h0C, read_exp(32'h0C), 0, 0);
    do_write(32'h20, 32'hCAFEF00D, 4'hF, 0, 2, 0);
    do_read(32'h40, read_exp(32'h40), 0, 2);
    do_write(32'h14, 32'hA5A5A5A5, 4'b0000, 0, 0, 0);
    do_read(32'h14, read_exp(32'h14), 0, 0);
    do_both(32'h10, 32'h0BADC0DE, 4'hF, 32'h04, 5, 5);
    do_both(32'h04, 32'h11112222, 4'hF, 32'h04, 0, 1);
    do_read(32'h04, read_exp(32'h04), 0, 0);

    for (int it = 0; it < 60; it++) begin
      op = $urandom_range(0, 2);
      a  = 32'($urandom_range(0, 11) * 4 + $urandom_range(0, 3));
      ra = 32'($urandom_range(0, 11) * 4 + $urandom_range(0, 3));
      d  = $urandom;
      case (op)
        0: do_write(a, d, 4'($urandom_range(0, 15)), $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 3));
        1: do_read(ra, read_exp(ra), $urandom_range(0, 3), $urandom_range(0, 3));
        default: do_both(a, d, 4'($urandom_range(0, 15)), ra, $urandom_range(0, 3), $urandom_range(0, 3));
      endcase
    end

    // Reset while a write response is pending: the response is abandoned.
    model[1] = 32'h55AA55AA;
    exp_wr.push_back(NR'(2));
    awaddr = 32'h04; wdata = 32'h55AA55AA; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    @(posedge aclk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge aclk);
    chk("pre_reset_bvalid", bvalid, 1);
    chk("pre_reset_reg1", reg_q[63:32], 32'h55AA55AA);
    #2;
    areset = 1'b1;
    #1;
    chk("async_bvalid", bvalid, 0);
    chk("async_awready", awready, 0);
    chk("async_wready", wready, 0);
    chk("async_arready", arready, 0);
    for (int i = 0; i < NR; i++) begin
      model[i] = 32'h0;
      chk("async_reg_q", reg_q[32*i +: 32], 32'h0);
    end
    @(negedge aclk);
    chk("held_awready", awready, 0);
    areset = 1'b0;
    #1;
    chk("rel2_awready", awready, 1);
    chk("rel2_arready", arready, 1);
    @(posedge aclk); #1;
    do_write(32'h1C, 32'h76543210, 4'hF, 0, 0, 0);
    do_read(32'h1C, read_exp(32'h1C), 0, 0);

    repeat (3) @(posedge aclk);
    chk("exp_b_left", exp_b.size(), 0);
    chk("exp_r_left", exp_r.size(), 0);
    chk("exp_wr_left", exp_wr.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
